rf_cmd_ctrl: RTL and testbench
==============================

Name: rf_cmd_ctrl

Overview:
- Command front-end directly upstream of the register file.
- Parses byte-serial commands arriving from the UART receiver and drives the register-file write/read strobes, address and write data.
- Captures read data and hands it to the UART transmitter over a valid/busy handshake.
- Sits between UART RX/TX and the register file in the configurable multi-clock system.

Parameters:
- Width, 8, data/command byte width (matches register-file word)
- Depth, 16, register-file depth; address width = $clog2(Depth)
- WR_CMD, 8'hAA, opcode for "write register"
- RD_CMD, 8'hBB, opcode for "read register"
- WAIT_MAX, 4, max cycles to wait for RdData_VLD before abort

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  Width  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- RdData  in  Width  register-file read data
- RdData_VLD  in  1  register-file read-data valid
- TX_Busy  in  1  transmitter busy; high blocks a new TX request
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  $clog2(Depth)  register-file address
- WrData  out  Width  register-file write data
- TX_P_DATA  out  Width  byte to transmit
- TX_D_VLD  out  1  one-cycle TX request
- Cmd_Err  out  1  one-cycle pulse on unknown opcode, dropped byte or read timeout

Behaviour:
- Interface decision: one clock, CLK; reset RST is asynchronous and active-low.
- All outputs are registered. While RST is low, every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_STROBE, RD_ADDR, RD_STROBE, RD_WAIT, TX_SEND.
- IDLE:
  - RX_D_VLD with byte == WR_CMD -> WR_ADDR.
  - RX_D_VLD with byte == RD_CMD -> RD_ADDR.
  - Any other byte -> Cmd_Err pulse next cycle, stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch RX_P_DATA[AW-1:0] into Address; upper bits are ignored -> WR_DATA.
- WR_DATA: on RX_D_VLD, latch WrData -> WR_STROBE.
- WR_STROBE:
  - WrEn=1 for exactly one cycle, RdEn=0, Address/WrData stable.
  - Write completes 1 cycle after the data byte's RX_D_VLD cycle -> IDLE.
- RD_ADDR: on RX_D_VLD, latch Address -> RD_STROBE.
- RD_STROBE: RdEn=1 for exactly one cycle, WrEn=0 -> RD_WAIT.
- RD_WAIT:
  - Wait-counter starts at 0. On RdData_VLD, capture RdData into TX_P_DATA -> TX_SEND.
  - If the counter reaches WAIT_MAX with no RdData_VLD -> Cmd_Err pulse, return to IDLE.
- TX_SEND:
  - While TX_Busy=1, hold with TX_P_DATA stable.
  - First cycle with TX_Busy=0: TX_D_VLD=1 for exactly one cycle -> IDLE.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their last value outside the strobe cycles.
- RX_D_VLD arriving in WR_STROBE, RD_STROBE, RD_WAIT or TX_SEND: byte dropped, Cmd_Err pulse, no state change.
- Back-to-back bytes on consecutive cycles are accepted in IDLE/WR_ADDR/WR_DATA/RD_ADDR.
- Reset asserted mid-command: FSM returns to IDLE; pending TX and partial command are discarded.
- Latency:
  - Data byte -> WrEn: 1 cycle.
  - Address byte -> RdEn: 1 cycle.
  - RdData_VLD -> TX_D_VLD: 1 cycle minimum, plus TX_Busy stall.

Decomposition:
- Shared package: state encoding enum, WR_CMD/RD_CMD default opcodes, address-width function.
- One natural sub-module: rf_rd_timeout, the saturating wait counter with clear/enable/expired flag.
- Remainder stays a single FSM module.

Test Plan:
- Write: reset; RX bytes AA, 05, 3C on consecutive RX_D_VLD pulses -> WrEn=1 for one cycle with Address=5, WrData=8'h3C, 1 cycle after the 3C byte. Then BB,05 -> TX_P_DATA=3C, TX_D_VLD single pulse.
- Read with busy TX: TX_Busy=1; send BB, 02 with the RF model returning 8'h21 one cycle after RdEn -> TX_D_VLD stays 0 while busy. Drop TX_Busy -> TX_D_VLD=1 next cycle with TX_P_DATA=8'h21.
- Timeout: BB, 07 with RdData_VLD never asserted -> Cmd_Err pulse after WAIT_MAX cycles in RD_WAIT, FSM back in IDLE. Then AA, 01, 55 writes correctly.
- Bad opcode/drop: RX byte 8'h12 in IDLE -> Cmd_Err pulse, no WrEn/RdEn. RX byte during RD_WAIT -> Cmd_Err pulse, read completes normally.
- Reset mid-command: AA, 09, then assert RST before the data byte -> all outputs 0. After release, byte 77 alone yields Cmd_Err, not a write.
- Mutual exclusion: randomized command stream of 200 commands -> assertion that WrEn&RdEn is never 1 and every strobe lasts exactly one cycle.

Source files
------------

// File: rtl/rf_cmd_ctrl_pkg.sv
// Shared definitions for the register-file command front-end:
// FSM state encoding, default opcodes and address-width helper.
package rf_cmd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_WR_STROBE,
      ST_RD_ADDR,
      ST_RD_STROBE,
      ST_RD_WAIT,
      ST_TX_SEND
   } state_t;

   localparam logic [7:0] DEF_WR_CMD = 8'hAA;
   localparam logic [7:0] DEF_RD_CMD = 8'hBB;

   // A one-entry register file still needs a one-bit address port.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rf_rd_timeout.sv
// Saturating read-wait counter; o_expired marks the waiting cycle whose
// count takes the counter to WAIT_MAX.
module rf_rd_timeout #(
   parameter int WAIT_MAX = 4
)(
   input  logic CLK,
   input  logic RST,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = $clog2(WAIT_MAX + 1);

   logic [CW-1:0] r_cnt;
   logic          w_sat;

   assign w_sat     = (r_cnt == CW'(WAIT_MAX));
   assign o_expired = i_en && (r_cnt == CW'(WAIT_MAX - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_sat) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/rf_cmd_ctrl.sv
// Byte-serial command parser between UART RX/TX and the register file:
// decodes write/read commands, strobes the register file, returns read data.
module rf_cmd_ctrl
   import rf_cmd_ctrl_pkg::*;
#(
   parameter int               Width    = 8,
   parameter int               Depth    = 16,
   parameter logic [Width-1:0] WR_CMD   = Width'(DEF_WR_CMD),
   parameter logic [Width-1:0] RD_CMD   = Width'(DEF_RD_CMD),
   parameter int               WAIT_MAX = 4
)(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [Width-1:0]         RX_P_DATA,
   input  logic                     RX_D_VLD,
   input  logic [Width-1:0]         RdData,
   input  logic                     RdData_VLD,
   input  logic                     TX_Busy,
   output logic                     WrEn,
   output logic                     RdEn,
   output logic [addr_w(Depth)-1:0] Address,
   output logic [Width-1:0]         WrData,
   output logic [Width-1:0]         TX_P_DATA,
   output logic                     TX_D_VLD,
   output logic                     Cmd_Err
);

   localparam int AW = addr_w(Depth);

   state_t r_state;
   logic   w_tmo_clr;
   logic   w_tmo_en;
   logic   w_tmo;

   assign w_tmo_clr = (r_state == ST_RD_STROBE);
   assign w_tmo_en  = (r_state == ST_RD_WAIT);

   rf_rd_timeout #(
      .WAIT_MAX (WAIT_MAX)
   ) u_rd_timeout (
      .CLK       (CLK),
      .RST       (RST),
      .i_clr     (w_tmo_clr),
      .i_en      (w_tmo_en),
      .o_expired (w_tmo)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= ST_IDLE;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         Cmd_Err   <= 1'b0;
      end else begin
         WrEn     <= 1'b0;
         RdEn     <= 1'b0;
         TX_D_VLD <= 1'b0;
         Cmd_Err  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == WR_CMD) begin
                     r_state <= ST_WR_ADDR;
                  end else if (RX_P_DATA == RD_CMD) begin
                     r_state <= ST_RD_ADDR;
                  end else begin
                     Cmd_Err <= 1'b1;
                  end
               end
            end

            ST_WR_ADDR: begin
               if (RX_D_VLD) begin
                  Address <= RX_P_DATA[AW-1:0];
                  r_state <= ST_WR_DATA;
               end
            end

            ST_WR_DATA: begin
               if (RX_D_VLD) begin
                  WrData  <= RX_P_DATA;
                  WrEn    <= 1'b1;
                  r_state <= ST_WR_STROBE;
               end
            end

            ST_WR_STROBE: begin
               Cmd_Err <= RX_D_VLD;
               r_state <= ST_IDLE;
            end

            ST_RD_ADDR: begin
               if (RX_D_VLD) begin
                  Address <= RX_P_DATA[AW-1:0];
                  RdEn    <= 1'b1;
                  r_state <= ST_RD_STROBE;
               end
            end

            ST_RD_STROBE: begin
               Cmd_Err <= RX_D_VLD;
               r_state <= ST_RD_WAIT;
            end

            // Read data wins over a timeout landing in the same cycle.
            ST_RD_WAIT: begin
               Cmd_Err <= RX_D_VLD;
               if (RdData_VLD) begin
                  TX_P_DATA <= RdData;
                  TX_D_VLD  <= !TX_Busy;
                  r_state   <= ST_TX_SEND;
               end else if (w_tmo) begin
                  Cmd_Err <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end

            // TX_D_VLD high here means the request has gone out this cycle.
            ST_TX_SEND: begin
               Cmd_Err <= RX_D_VLD;
               if (TX_D_VLD) begin
                  r_state <= ST_IDLE;
               end else if (!TX_Busy) begin
                  TX_D_VLD <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Scoreboard bench for rf_cmd_ctrl: command-level driver predicts every
// strobe, TX request and error pulse with its cycle; a monitor checks them.
module tb_rf_cmd_ctrl;

   localparam int         Width    = 8;
   localparam int         Depth    = 16;
   localparam int         AW       = 4;
   localparam int         WAIT_MAX = 4;
   localparam logic [7:0] WR       = 8'hAA;
   localparam logic [7:0] RD       = 8'hBB;

   logic             CLK        = 1'b0;
   logic             RST        = 1'b1;
   logic [Width-1:0] RX_P_DATA  = '0;
   logic             RX_D_VLD   = 1'b0;
   logic [Width-1:0] RdData     = '0;
   logic             RdData_VLD = 1'b0;
   logic             TX_Busy    = 1'b0;
   logic             WrEn;
   logic             RdEn;
   logic [AW-1:0]    Address;
   logic [Width-1:0] WrData;
   logic [Width-1:0] TX_P_DATA;
   logic             TX_D_VLD;
   logic             Cmd_Err;

   rf_cmd_ctrl #(
      .Width    (Width),
      .Depth    (Depth),
      .WR_CMD   (WR),
      .RD_CMD   (RD),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_P_DATA  (RX_P_DATA),
      .RX_D_VLD   (RX_D_VLD),
      .RdData     (RdData),
      .RdData_VLD (RdData_VLD),
      .TX_Busy    (TX_Busy),
      .WrEn       (WrEn),
      .RdEn       (RdEn),
      .Address    (Address),
      .WrData     (WrData),
      .TX_P_DATA  (TX_P_DATA),
      .TX_D_VLD   (TX_D_VLD),
      .Cmd_Err    (Cmd_Err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] a;
      logic [7:0] d;
   } ev_t;

   ev_t        wr_q[$];
   ev_t        rd_q[$];
   ev_t        tx_q[$];
   int         err_q[$];
   logic [7:0] mem [Depth];
   int         n_tests = 0;
   int         n_fail  = 0;
   bit         done    = 1'b0;
   bit         drained = 1'b0;

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      ev_t e;
      forever begin
         @(negedge CLK);
         while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL wr_missing: WrEn=0 at cycle %0d, required 1", wr_q[0].cyc);
            void'(wr_q.pop_front());
         end
         while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL rd_missing: RdEn=0 at cycle %0d, required 1", rd_q[0].cyc);
            void'(rd_q.pop_front());
         end
         while (tx_q.size() > 0 && tx_q[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL tx_missing: TX_D_VLD=0 at cycle %0d, required 1", tx_q[0].cyc);
            void'(tx_q.pop_front());
         end
         while (err_q.size() > 0 && err_q[0] < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL err_missing: Cmd_Err=0 at cycle %0d, required 1", err_q[0]);
            void'(err_q.pop_front());
         end

         if (!RST) begin
            n_tests++;
            if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err} != '0) begin
               n_fail++;
               $display("FAIL reset_outputs: got WrEn=%b RdEn=%b Addr=%h WrData=%h TX=%h TXV=%b Err=%b, required all 0",
                        WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err);
            end
         end else begin
            if (WrEn || RdEn) begin
               n_tests++;
               if (WrEn && RdEn) begin
                  n_fail++;
                  $display("FAIL strobe_excl: WrEn=1 RdEn=1 at cycle %0d, required not both", cyc);
               end
            end
            if (WrEn) begin
               n_tests++;
               if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
                  n_fail++;
                  $display("FAIL wr_unexpected: WrEn=1 at cycle %0d, required 0", cyc);
               end else begin
                  e = wr_q.pop_front();
                  if (Address != e.a[AW-1:0] || WrData != e.d) begin
                     n_fail++;
                     $display("FAIL wr_data: got addr %h data %h, required addr %h data %h",
                              Address, WrData, e.a[AW-1:0], e.d);
                  end
               end
            end
            if (RdEn) begin
               n_tests++;
               if (rd_q.size() == 0 || rd_q[0].cyc != cyc) begin
                  n_fail++;
                  $display("FAIL rd_unexpected: RdEn=1 at cycle %0d, required 0", cyc);
               end else begin
                  e = rd_q.pop_front();
                  if (Address != e.a[AW-1:0]) begin
                     n_fail++;
                     $display("FAIL rd_addr: got %h, required %h", Address, e.a[AW-1:0]);
                  end
               end
            end
            if (TX_D_VLD) begin
               n_tests++;
               if (tx_q.size() == 0 || tx_q[0].cyc != cyc) begin
                  n_fail++;
                  $display("FAIL tx_unexpected: TX_D_VLD=1 at cycle %0d, required 0", cyc);
               end else begin
                  e = tx_q.pop_front();
                  if (TX_P_DATA != e.d) begin
                     n_fail++;
                     $display("FAIL tx_data: got %h, required %h", TX_P_DATA, e.d);
                  end
               end
            end
            if (Cmd_Err) begin
               n_tests++;
               if (err_q.size() == 0 || err_q[0] != cyc) begin
                  n_fail++;
                  $display("FAIL err_unexpected: Cmd_Err=1 at cycle %0d, required 0", cyc);
               end else begin
                  void'(err_q.pop_front());
               end
            end
         end

         if (done && !drained) begin
            n_tests++;
            if (wr_q.size() + rd_q.size() + tx_q.size() + err_q.size() != 0) begin
               n_fail++;
               $display("FAIL queue_drain: %0d expected events outstanding, required 0",
                        wr_q.size() + rd_q.size() + tx_q.size() + err_q.size());
            end
            drained = 1'b1;
         end
      end
   end

   // ---------------- driver / reference model ----------------
   task automatic nxt();
      @(negedge CLK);
      RX_D_VLD   = 1'b0;
      RdData_VLD = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      nxt();
   endtask

   task automatic idle(input int n);
      repeat (n) nxt();
   endtask

   // Byte arriving while the controller is busy: dropped, error next cycle.
   task automatic drop();
      RX_P_DATA = 8'($urandom);
      RX_D_VLD  = 1'b1;
      err_q.push_back(cyc + 1);
   endtask

   task automatic do_bad(input logic [7:0] b);
      if (b == WR || b == RD) b = 8'h12;
      err_q.push_back(cyc + 1);
      send(b);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gmax, input bit dstb);
      send(WR);
      idle(int'($urandom_range(0, gmax)));
      send(a);
      idle(int'($urandom_range(0, gmax)));
      wr_q.push_back('{cyc: cyc + 1, a: a, d: d});
      send(d);
      mem[a[AW-1:0]] = d;
      if (dstb) drop();
      nxt();
   endtask

   // lat: cycles from RdEn to RdData_VLD (0 = never); busy: TX_Busy cycles
   // from the data cycle; dk: RD_WAIT cycle index carrying a stray byte.
   task automatic do_read(input logic [7:0] a, input int lat, input int busy, input int dk,
                          input bit dstb, input bit dbsy, input int gmax);
      logic [7:0] d;
      send(RD);
      idle(int'($urandom_range(0, gmax)));
      rd_q.push_back('{cyc: cyc + 1, a: a, d: 8'h00});
      send(a);
      if (dstb) drop();
      nxt();
      for (int k = 0; k < WAIT_MAX; k++) begin
         if (k == lat - 1) begin
            d          = mem[a[AW-1:0]];
            RdData     = d;
            RdData_VLD = 1'b1;
            for (int j = 0; j < 64; j++) begin
               TX_Busy = (j < busy);
               if (!TX_Busy) begin
                  tx_q.push_back('{cyc: cyc + 1, a: 8'h00, d: d});
                  nxt();
                  nxt();
                  return;
               end
               if (j > 0 && dbsy) drop();
               nxt();
            end
            TX_Busy = 1'b0;
            return;
         end
         RdData = 8'($urandom);
         if (k == dk) drop();
         if (k == WAIT_MAX - 1) err_q.push_back(cyc + 1);
         nxt();
      end
   endtask

   initial begin
      int sel;
      int lat;
      int dk;
      for (int i = 0; i < Depth; i++) mem[i] = 8'($urandom);

      #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;

      do_write(8'h05, 8'h3C, 0, 1'b0);
      do_read(8'h05, 1, 0, -1, 1'b0, 1'b0, 0);
      mem[2] = 8'h21;
      do_read(8'h02, 1, 4, -1, 1'b0, 1'b0, 0);
      do_read(8'h07, 0, 0, -1, 1'b0, 1'b0, 0);
      do_write(8'h01, 8'h55, 0, 1'b0);
      do_read(8'h01, 2, 0, -1, 1'b0, 1'b0, 0);
      do_bad(8'h12);
      do_read(8'h03, 3, 0, 0, 1'b0, 1'b0, 0);
      do_write(8'hF9, 8'hA5, 0, 1'b1);
      do_read(8'h09, 1, 2, -1, 1'b1, 1'b1, 0);
      do_read(8'h0E, WAIT_MAX, 0, -1, 1'b0, 1'b0, 1);

      // Reset in the middle of a write command.
      send(WR);
      send(8'h09);
      #2 RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      do_bad(8'h77);
      do_read(8'h09, 1, 0, -1, 1'b0, 1'b0, 0);

      for (int n = 0; n < 200; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 4) begin
            do_write(8'($urandom), 8'($urandom), 2, 1'($urandom));
         end else if (sel < 8) begin
            lat = int'($urandom_range(0, WAIT_MAX));
            dk  = -1;
            if (lat == 0 && $urandom_range(0, 1) == 1)
               dk = int'($urandom_range(0, WAIT_MAX - 2));
            else if (lat > 1 && $urandom_range(0, 1) == 1)
               dk = int'($urandom_range(0, lat - 2));
            do_read(8'($urandom), lat, int'($urandom_range(0, 3)), dk,
                    1'($urandom), 1'($urandom), 2);
         end else if (sel == 8) begin
            do_bad(8'($urandom));
         end else begin
            idle(int'($urandom_range(1, 3)));
         end
      end

      idle(8);
      done = 1'b1;
      for (int i = 0; i < 20 && !drained; i++) @(negedge CLK);
      if (!drained) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: final check not reached, required within 20 cycles");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
